// File: rtl/clkdiv_pkg.sv
// Shared constants and ratio coercion for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_MIN_DIV = 2;
    localparam int unsigned CLKDIV_WIDTH   = 16;

    // Ratios below the minimum are coerced up; there is no bypass path.
    function automatic int unsigned eff_div(input int unsigned d);
        return (d < CLKDIV_MIN_DIV) ? CLKDIV_MIN_DIV : d;
    endfunction

endpackage

// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog. CLKDIV_SYNC_EN adds the sync phase-align input.
interface clock_divider_prog_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH = CLKDIV_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] div;
`ifdef CLKDIV_SYNC_EN
    logic             sync;
`endif
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] count;

`ifdef CLKDIV_SYNC_EN
    modport master (output en, div, sync, input clk_out, tick, count);
    modport slave  (input en, div, sync, output clk_out, tick, count);
`else
    modport master (output en, div, input clk_out, tick, count);
    modport slave  (input en, div, output clk_out, tick, count);
`endif

endinterface

// File: rtl/clock_divider_prog.sv
// Synchronous programmable divider: near-50% clk_out level plus one-cycle tick enable strobe.
// Optional CLKDIV_SYNC_EN adds a sync input that restarts the period for phase alignment.
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH = CLKDIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_divider_prog_if.slave  bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] div_eff;
    logic             wrap;
    logic             clk_out_q;
    logic             tick_q;
    logic             sync_c;

`ifdef CLKDIV_SYNC_EN
    assign sync_c = bus.sync;
`else
    assign sync_c = 1'b0;
`endif

    // Next counter value and the high-phase length of the active ratio
    always_comb begin
        wrap     = (cnt == div_q - WIDTH'(1));
        cnt_next = wrap ? '0 : cnt + WIDTH'(1);
        half     = div_q >> 1;
        div_eff  = WIDTH'(eff_div(32'(bus.div)));
    end

    // New ratios load only at the period boundary, so no runt pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            div_q     <= div_eff;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else if (sync_c) begin
            cnt       <= '0;
            div_q     <= div_eff;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
        end else if (bus.en) begin
            cnt       <= cnt_next;
            clk_out_q <= (cnt_next < half);
            tick_q    <= wrap;
            if (wrap) begin
                div_q <= div_eff;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign bus.count   = cnt;
    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed scenarios plus randomized run against a period-level model.
module tb_clock_divider_prog;

    localparam int unsigned W = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    clock_divider_prog_if #(.WIDTH(W)) bus ();

    clock_divider_prog #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position within the current period and the period length
    int unsigned m_pos;
    int unsigned m_per;
    bit          m_clk;
    bit          m_tick;
    bit          m_valid;

    function automatic int unsigned ref_eff(input int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit sync_in();
`ifdef CLKDIV_SYNC_EN
        return bus.sync;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        int unsigned h;
        if (reset) begin
            m_pos = 0; m_per = ref_eff(32'(bus.div)); m_clk = 0; m_tick = 0; m_valid = 1;
        end else if (sync_in()) begin
            m_pos = 0; m_per = ref_eff(32'(bus.div)); m_clk = 1; m_tick = 1;
        end else if (bus.en) begin
            h      = m_per / 2;
            m_pos  = (m_pos + 1) % m_per;
            m_tick = (m_pos == 0);
            m_clk  = (m_pos < h);
            if (m_tick) m_per = ref_eff(32'(bus.div));
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            check("count", 32'(bus.count), m_pos);
            check("clk_out", 32'(bus.clk_out), 32'(m_clk));
            check("tick", 32'(bus.tick), 32'(m_tick));
        end
    endtask

    task automatic do_reset(input int unsigned d);
        reset = 1'b1; bus.div = W'(d); bus.en = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Runs until a tick; period = edges seen, hi = edges with clk_out high
    task automatic measure(output int per, output int hi);
        bit got_tick;
        per = 0; hi = 0; got_tick = 0;
        for (int i = 0; i < 200 && !got_tick; i++) begin
            cycle();
            per++;
            if (bus.clk_out) hi++;
            if (bus.tick) got_tick = 1;
        end
        if (!got_tick) per = -1;
    endtask

    initial begin
        int per, hi;
        checks = 0; errors = 0; m_valid = 0;
        m_pos = 0; m_per = 2; m_clk = 0; m_tick = 0;
        reset = 1'b1; bus.en = 1'b0; bus.div = '0;
`ifdef CLKDIV_SYNC_EN
        bus.sync = 1'b0;
`endif

        // div=4 after reset: count 1,2,3,0; clk_out 1,0,0,1; tick on edges 4,8,12
        do_reset(4);
        check("rst_count", 32'(bus.count), 0);
        check("rst_clk", 32'(bus.clk_out), 0);
        check("rst_tick", 32'(bus.tick), 0);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("d4_count", 32'(bus.count), 32'(i % 4));
            check("d4_clk", 32'(bus.clk_out), ((i % 4) < 2) ? 1 : 0);
            check("d4_tick", 32'(bus.tick), ((i % 4) == 0) ? 1 : 0);
        end

        // Odd ratio skews low
        do_reset(5);
        measure(per, hi);
        check("d5_first_per", per, 5);
        check("d5_first_hi", hi, 2);
        measure(per, hi);
        check("d5_per", per, 5);
        check("d5_hi", hi, 2);

        // Ratio change at cnt=1 finishes the current period first
        do_reset(4);
        cycle();
        bus.div = W'(6);
        measure(per, hi);
        check("chg_rest", per, 3);
        measure(per, hi);
        check("chg_per", per, 6);
        check("chg_hi", hi, 3);
        measure(per, hi);
        check("chg_per2", per, 6);

        // 0 and 1 behave as 2
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            measure(per, hi);
            check("low_div_per", per, 2);
            check("low_div_hi", hi, 1);
            measure(per, hi);
            check("low_div_per2", per, 2);
        end

        // en low freezes state and suppresses tick; period stretches
        do_reset(4);
        cycle();
        bus.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("hold_count", 32'(bus.count), 1);
            check("hold_clk", 32'(bus.clk_out), 1);
            check("hold_tick", 32'(bus.tick), 0);
        end
        bus.en = 1'b1;
        measure(per, hi);
        check("hold_period", 32'(3 + per), 6);

        // Mid-period reset
        do_reset(4);
        cycle();
        cycle();
        check("pre_rst_count", 32'(bus.count), 2);
        reset = 1'b1;
        cycle();
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_clk", 32'(bus.clk_out), 0);
        check("mid_rst_tick", 32'(bus.tick), 0);
        reset = 1'b0;

`ifdef CLKDIV_SYNC_EN
        do_reset(4);
        cycle();
        cycle();
        bus.sync = 1'b1; bus.en = 1'b0;
        cycle();
        check("sync_tick", 32'(bus.tick), 1);
        check("sync_clk", 32'(bus.clk_out), 1);
        check("sync_count", 32'(bus.count), 0);
        bus.sync = 1'b0; bus.en = 1'b1;
        measure(per, hi);
        check("sync_per", per, 4);
`endif

        // Randomized run against the model
        do_reset($urandom_range(0, 9));
        for (int i = 0; i < 3000; i++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.div = W'($urandom_range(0, 40));
            reset = ($urandom_range(0, 149) == 0);
`ifdef CLKDIV_SYNC_EN
            bus.sync = ($urandom_range(0, 99) == 0);
`endif
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
